// File: rtl/cps2_video_tx.sv
// cps2_video_tx: transmit-side CPS2 video timing generator.
// Walks a (slot, line) raster at two PCLK cycles per pixel slot, fetches the
// next slot's pixel from a one-cycle-latency source, and emits native-format
// 4-bit R/G/B/F video with active-low syncs, an active-area flag and a
// frame-start pulse. All outputs are registered.
//
// Ports:
//   PCLK_i           clock, twice the pixel rate
//   RST_i            synchronous active-high reset
//   pix_req_o        one-cycle fetch strobe for the next slot's pixel
//   req_x_o/req_y_o  coordinates of the requested pixel, held between requests
//   R_i..F_i         pixel data, valid one PCLK after pix_req_o
//   R_o..F_o         video out, zero outside the active area
//   HSYNC_o/VSYNC_o  active-low syncs
//   DE_o             active-area flag
//   frame_start_o    one-cycle pulse on the first cycle of slot (0,0)
module cps2_video_tx #(
    parameter int unsigned H_TOTAL     = 512,
    parameter int unsigned H_SYNCLEN   = 36,
    parameter int unsigned H_BACKPORCH = 62,
    parameter int unsigned H_ACTIVE    = 384,
    parameter int unsigned V_TOTAL     = 262,
    parameter int unsigned V_SYNCLEN   = 3,
    parameter int unsigned V_BACKPORCH = 22,
    parameter int unsigned V_ACTIVE    = 224
) (
    input  logic       PCLK_i,
    input  logic       RST_i,
    output logic       pix_req_o,
    output logic [8:0] req_x_o,
    output logic [8:0] req_y_o,
    input  logic [3:0] R_i,
    input  logic [3:0] G_i,
    input  logic [3:0] B_i,
    input  logic [3:0] F_i,
    output logic [3:0] R_o,
    output logic [3:0] G_o,
    output logic [3:0] B_o,
    output logic [3:0] F_o,
    output logic       HSYNC_o,
    output logic       VSYNC_o,
    output logic       DE_o,
    output logic       frame_start_o
);

    localparam logic [8:0] H_LAST     = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST     = 9'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_END = 10'(H_SYNCLEN);
    localparam logic [8:0] V_SYNC_END = 9'(V_SYNCLEN);
    localparam logic [9:0] H_START    = 10'(H_SYNCLEN + H_BACKPORCH);
    localparam logic [9:0] H_END      = 10'(H_SYNCLEN + H_BACKPORCH + H_ACTIVE);
    localparam logic [8:0] V_START    = 9'(V_SYNCLEN + V_BACKPORCH);
    localparam logic [8:0] V_END      = 9'(V_SYNCLEN + V_BACKPORCH + V_ACTIVE);

    // Counters hold the slot currently shown on the outputs.
    logic [8:0] h_q, h_d;
    logic [8:0] v_q, v_d;
    logic       p_q, p_d;

    logic [9:0] h_ext, h_nxt;
    logic       v_act, de_d, req_d, hs_d, vs_d, fs_d;
    logic [8:0] req_x_d, req_y_d;

    always_comb begin
        p_d = ~p_q;
        h_d = h_q;
        v_d = v_q;
        if (p_q) begin
            if (h_q == H_LAST) begin
                h_d = 9'd0;
                v_d = (v_q == V_LAST) ? 9'd0 : v_q + 9'd1;
            end else begin
                h_d = h_q + 9'd1;
            end
        end

        // Outputs are registered from the next slot so they line up with it.
        h_ext   = {1'b0, h_d};
        h_nxt   = h_ext + 10'd1;
        v_act   = (v_d >= V_START) && (v_d < V_END);
        de_d    = (h_ext >= H_START) && (h_ext < H_END) && v_act;
        req_d   = ~p_d && (h_nxt >= H_START) && (h_nxt < H_END) && v_act;
        hs_d    = (h_ext >= H_SYNC_END);
        vs_d    = (v_d >= V_SYNC_END);
        fs_d    = ~p_d && (h_d == 9'd0) && (v_d == 9'd0);
        req_x_d = 9'(h_nxt - H_START);
        req_y_d = v_d - V_START;
    end

    always_ff @(posedge PCLK_i) begin
        if (RST_i) begin
            // Park on the last phase of the last slot so the first free edge
            // wraps cleanly into slot (0,0) phase 0.
            h_q           <= H_LAST;
            v_q           <= V_LAST;
            p_q           <= 1'b1;
            HSYNC_o       <= 1'b1;
            VSYNC_o       <= 1'b1;
            DE_o          <= 1'b0;
            frame_start_o <= 1'b0;
            pix_req_o     <= 1'b0;
            req_x_o       <= 9'd0;
            req_y_o       <= 9'd0;
            R_o           <= 4'd0;
            G_o           <= 4'd0;
            B_o           <= 4'd0;
            F_o           <= 4'd0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            p_q           <= p_d;
            HSYNC_o       <= hs_d;
            VSYNC_o       <= vs_d;
            DE_o          <= de_d;
            frame_start_o <= fs_d;
            pix_req_o     <= req_d;
            if (req_d) begin
                req_x_o <= req_x_d;
                req_y_o <= req_y_d;
            end
            // Pixel data fetched in the previous slot is valid on the edge
            // that enters the new slot; hold it through the second phase.
            if (!p_d) begin
                R_o <= de_d ? R_i : 4'd0;
                G_o <= de_d ? G_i : 4'd0;
                B_o <= de_d ? B_i : 4'd0;
                F_o <= de_d ? F_i : 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_cps2_video_tx.sv
// Directed bench for cps2_video_tx. One instance uses the default CPS2 raster;
// a second, shrunken raster (16x12 slots, 8x6 active) makes whole-frame
// checks affordable. A one-cycle-latency pixel source answers each request
// with {x[3:0], y[3:0], x[7:4], 4'hA}, or all-F when force_f is set.
module tb_cps2_video_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic force_f = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Default-raster instance
    logic       req, hs, vs, de, fs;
    logic [8:0] rx, ry;
    logic [3:0] ri = 4'd0, gi = 4'd0, bi = 4'd0, fi = 4'd0;
    logic [3:0] ro, go, bo, fo;

    // Small-raster instance
    logic       req_s, hs_s, vs_s, de_s, fs_s;
    logic [8:0] rx_s, ry_s;
    logic [3:0] ri_s = 4'd0, gi_s = 4'd0, bi_s = 4'd0, fi_s = 4'd0;
    logic [3:0] ro_s, go_s, bo_s, fo_s;

    cps2_video_tx dut (
        .PCLK_i(clk), .RST_i(rst), .pix_req_o(req), .req_x_o(rx), .req_y_o(ry),
        .R_i(ri), .G_i(gi), .B_i(bi), .F_i(fi),
        .R_o(ro), .G_o(go), .B_o(bo), .F_o(fo),
        .HSYNC_o(hs), .VSYNC_o(vs), .DE_o(de), .frame_start_o(fs)
    );

    cps2_video_tx #(
        .H_TOTAL(16), .H_SYNCLEN(2), .H_BACKPORCH(3), .H_ACTIVE(8),
        .V_TOTAL(12), .V_SYNCLEN(1), .V_BACKPORCH(2), .V_ACTIVE(6)
    ) dut_s (
        .PCLK_i(clk), .RST_i(rst), .pix_req_o(req_s), .req_x_o(rx_s), .req_y_o(ry_s),
        .R_i(ri_s), .G_i(gi_s), .B_i(bi_s), .F_i(fi_s),
        .R_o(ro_s), .G_o(go_s), .B_o(bo_s), .F_o(fo_s),
        .HSYNC_o(hs_s), .VSYNC_o(vs_s), .DE_o(de_s), .frame_start_o(fs_s)
    );

    // Block-RAM-like pixel sources
    always @(posedge clk) begin
        if (force_f) begin
            {ri, gi, bi, fi} <= 16'hFFFF;
        end else if (req) begin
            {ri, gi, bi, fi} <= {rx[3:0], ry[3:0], rx[7:4], 4'hA};
        end
        if (req_s) begin
            {ri_s, gi_s, bi_s, fi_s} <= {rx_s[3:0], ry_s[3:0], rx_s[7:4], 4'hA};
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reset, release, and leave cyc=0 on the first cycle of slot (0,0).
    task automatic do_reset;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        cyc = 0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (5) tick();
        checks++;
        if ({hs, vs, de, req, fs} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 11000", {hs, vs, de, req, fs});
        end
        checks++;
        if ({ro, go, bo, fo, rx, ry} !== 34'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {ro, go, bo, fo, rx, ry});
        end
        checks++;
        if ({hs_s, vs_s, de_s, req_s, fs_s, ro_s, go_s, bo_s, fo_s} !== 21'h180000) begin
            errors++;
            $display("FAIL reset_small: got %h expected 180000",
                     {hs_s, vs_s, de_s, req_s, fs_s, ro_s, go_s, bo_s, fo_s});
        end
        rst = 1'b0;
        tick();
        cyc = 0;
        checks++;
        if ({hs, vs, fs} !== 3'b001) begin
            errors++;
            $display("FAIL release_first: got %b expected 001", {hs, vs, fs});
        end
        tick();
        checks++;
        if ({hs, vs, fs} !== 3'b000) begin
            errors++;
            $display("FAIL release_pulse_width: got %b expected 000", {hs, vs, fs});
        end
    endtask

    task automatic test_line_timing;
        int falls[$];
        int low0 = 0;
        int de_cnt = 0;
        logic prev_hs = 1'b1;
        do_reset();
        for (int i = 0; i < 3 * 1024; i++) begin
            if (prev_hs && !hs) falls.push_back(cyc);
            if (!hs && cyc < 1024) low0++;
            if (de) de_cnt++;
            prev_hs = hs;
            tick();
        end
        checks++;
        if (falls.size() != 3) begin
            errors++;
            $display("FAIL hsync_fall_count: got %0d expected 3", falls.size());
        end else begin
            checks++;
            if (falls[1] - falls[0] != 1024 || falls[2] - falls[1] != 1024) begin
                errors++;
                $display("FAIL hsync_period: got %0d,%0d expected 1024,1024",
                         falls[1] - falls[0], falls[2] - falls[1]);
            end
        end
        checks++;
        if (low0 != 72) begin
            errors++;
            $display("FAIL hsync_low_width: got %0d expected 72", low0);
        end
        checks++;
        if (de_cnt != 0) begin
            errors++;
            $display("FAIL de_blank_lines: got %0d expected 0", de_cnt);
        end
    endtask

    // Continues from test_line_timing through active line 25.
    task automatic test_fetch;
        int de_rise = -1;
        int de_cnt = 0;
        int req_cnt = 0;
        int first_req = -1;
        logic [8:0] first_rx = 9'h1FF;
        logic [8:0] first_ry = 9'h1FF;
        logic prev_de = 1'b0;
        while (cyc < 26 * 1024) begin
            if (cyc >= 25 * 1024) begin
                if (de && !prev_de && de_rise < 0) de_rise = cyc;
                if (de) de_cnt++;
                if (req) begin
                    req_cnt++;
                    if (first_req < 0) begin
                        first_req = cyc;
                        first_rx = rx;
                        first_ry = ry;
                    end
                end
                if (cyc == 25796 || cyc == 25797) begin
                    checks++;
                    if ({de, ro, go, bo, fo} !== 17'h1000A) begin
                        errors++;
                        $display("FAIL pix_98_25: got %h expected 1000a", {de, ro, go, bo, fo});
                    end
                end
                if (cyc == 25798) begin
                    checks++;
                    if ({ro, go, bo, fo} !== 16'h100A) begin
                        errors++;
                        $display("FAIL pix_99_25: got %h expected 100a", {ro, go, bo, fo});
                    end
                end
                if (cyc == 26563) begin
                    checks++;
                    if ({ro, go, bo, fo, rx} !== {16'hF07A, 9'd383}) begin
                        errors++;
                        $display("FAIL pix_481_25: got %h/%0d expected f07a/383",
                                 {ro, go, bo, fo}, rx);
                    end
                end
                if (cyc == 26564) begin
                    checks++;
                    if ({de, ro, go, bo, fo} !== 17'h0) begin
                        errors++;
                        $display("FAIL pix_482_25: got %h expected 0", {de, ro, go, bo, fo});
                    end
                end
            end
            prev_de = de;
            tick();
        end
        checks++;
        if (de_rise != 25600 + 196) begin
            errors++;
            $display("FAIL de_start: got %0d expected %0d", de_rise, 25600 + 196);
        end
        checks++;
        if (de_cnt != 768) begin
            errors++;
            $display("FAIL de_width: got %0d expected 768", de_cnt);
        end
        checks++;
        if (req_cnt != 384) begin
            errors++;
            $display("FAIL req_per_line: got %0d expected 384", req_cnt);
        end
        checks++;
        if (first_req != 25794 || first_rx !== 9'd0 || first_ry !== 9'd0) begin
            errors++;
            $display("FAIL first_req: got cyc %0d x %0d y %0d expected 25794 0 0",
                     first_req, first_rx, first_ry);
        end
    endtask

    // Continues on line 26 with the source stuck at all-F.
    task automatic test_blanking;
        int bad = 0;
        force_f = 1'b1;
        while (cyc < 27 * 1024) begin
            if (!de && {ro, go, bo, fo} != 16'h0) bad++;
            if (cyc == 26624 + 401) begin
                checks++;
                if ({de, ro, go, bo, fo} !== 17'h1FFFF) begin
                    errors++;
                    $display("FAIL blank_active_pix: got %h expected 1ffff",
                             {de, ro, go, bo, fo});
                end
            end
            tick();
        end
        force_f = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL blank_nonzero: got %0d cycles expected 0", bad);
        end
    endtask

    // Small raster: line 32 PCLK, frame 384 PCLK, HS=5, VS=3.
    task automatic test_frame_timing;
        int vfalls[$];
        int vlow = 0;
        int fs_cnt = 0;
        int req_cnt = 0;
        int de_rises = 0;
        int de_cnt = 0;
        logic prev_vs = 1'b1;
        logic prev_de = 1'b0;
        do_reset();
        for (int i = 0; i < 2 * 384; i++) begin
            if (prev_vs && !vs_s) vfalls.push_back(cyc);
            if (!vs_s) vlow++;
            if (fs_s) fs_cnt++;
            if (req_s) req_cnt++;
            if (de_s && !prev_de) de_rises++;
            if (de_s) de_cnt++;
            if (cyc == 106) begin
                checks++;
                if ({de_s, ro_s, go_s, bo_s, fo_s} !== 17'h1000A) begin
                    errors++;
                    $display("FAIL s_first_pix: got %h expected 1000a",
                             {de_s, ro_s, go_s, bo_s, fo_s});
                end
            end
            if (cyc == 281) begin
                checks++;
                if ({de_s, ro_s, go_s, bo_s, fo_s} !== 17'h1750A) begin
                    errors++;
                    $display("FAIL s_last_pix: got %h expected 1750a",
                             {de_s, ro_s, go_s, bo_s, fo_s});
                end
            end
            if (cyc == 282) begin
                checks++;
                if ({de_s, ro_s, go_s, bo_s, fo_s} !== 17'h0) begin
                    errors++;
                    $display("FAIL s_after_last: got %h expected 0",
                             {de_s, ro_s, go_s, bo_s, fo_s});
                end
            end
            prev_vs = vs_s;
            prev_de = de_s;
            tick();
        end
        checks++;
        if (vfalls.size() != 2) begin
            errors++;
            $display("FAIL s_vsync_falls: got %0d expected 2", vfalls.size());
        end else begin
            checks++;
            if (vfalls[1] - vfalls[0] != 384) begin
                errors++;
                $display("FAIL s_frame_period: got %0d expected 384", vfalls[1] - vfalls[0]);
            end
        end
        checks++;
        if (vlow != 64) begin
            errors++;
            $display("FAIL s_vsync_low: got %0d expected 64", vlow);
        end
        checks++;
        if (fs_cnt != 2) begin
            errors++;
            $display("FAIL s_frame_start_count: got %0d expected 2", fs_cnt);
        end
        checks++;
        if (req_cnt != 96) begin
            errors++;
            $display("FAIL s_req_count: got %0d expected 96", req_cnt);
        end
        checks++;
        if (de_rises != 12 || de_cnt != 192) begin
            errors++;
            $display("FAIL s_de_lines: got %0d lines %0d cycles expected 12 192",
                     de_rises, de_cnt);
        end
    endtask

    task automatic test_reset_midframe;
        int first_s = -1;
        int first_m = -1;
        do_reset();
        while (cyc < 181) tick();
        // Small raster slot (10,5) phase 1: pixel (5,2).
        checks++;
        if ({de_s, ro_s, go_s, bo_s, fo_s} !== 17'h1520A) begin
            errors++;
            $display("FAIL mid_pix: got %h expected 1520a", {de_s, ro_s, go_s, bo_s, fo_s});
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({hs_s, vs_s, de_s, req_s, fs_s, ro_s, go_s, bo_s, fo_s, rx_s, ry_s} !==
            {5'b11000, 34'h0}) begin
            errors++;
            $display("FAIL mid_reset_vals: got %h expected %h",
                     {hs_s, vs_s, de_s, req_s, fs_s, ro_s, go_s, bo_s, fo_s, rx_s, ry_s},
                     {5'b11000, 34'h0});
        end
        rst = 1'b0;
        tick();
        cyc = 0;
        checks++;
        if ({fs_s, fs} !== 2'b11) begin
            errors++;
            $display("FAIL mid_restart_fs: got %b expected 11", {fs_s, fs});
        end
        while (cyc < 27000 && (first_s < 0 || first_m < 0)) begin
            if (req_s && first_s < 0) first_s = cyc;
            if (req && first_m < 0) first_m = cyc;
            tick();
        end
        checks++;
        if (first_s != 104) begin
            errors++;
            $display("FAIL mid_first_req_small: got %0d expected 104", first_s);
        end
        checks++;
        if (first_m != 97 * 2 + 25 * 1024) begin
            errors++;
            $display("FAIL mid_first_req: got %0d expected %0d", first_m, 97 * 2 + 25 * 1024);
        end
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_fetch();
        test_blanking();
        test_frame_timing();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
